// File: rtl/apb_completer_regs.sv
// APB completer terminating transfers into a bank of word registers,
// with programmable wait states and an error response for illegal accesses.
module apb_completer_regs #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  setup_err;
  logic [IDX_W-1:0]      setup_idx;
  logic                  go_access;

  assign setup_err = (paddr[1:0] != 2'b00) ||
    (paddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(NUM_REGS));
  assign setup_idx = paddr[IDX_W+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    idx_d     = idx_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    regs_d    = regs_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    go_access = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          write_d = pwrite;
          idx_d   = setup_idx;
          err_d   = setup_err;
          wdata_d = pwdata;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d   = S_ACCESS;
            go_access = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Dropping psel mid-transfer abandons it without touching registers.
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable) begin
          if (cnt_q <= 4'd1) begin
            state_d   = S_ACCESS;
            go_access = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (write_q && !err_q) begin
          regs_d[idx_q] = wdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Response is computed one cycle early so every output is a flop.
    if (go_access) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!err_d && !write_d) begin
        prdata_d = regs_q[idx_d];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: two instances (2 and 0 wait states)
// checked against an array model of the register bank.
module tb_apb_completer_regs;

  localparam int NR = 16;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel_a, psel_b;
  logic          penable, pwrite;
  logic [31:0]   paddr, pwdata;
  logic          pready_a, pready_b;
  logic          pslverr_a, pslverr_b;
  logic [31:0]   prdata_a, prdata_b;
  logic [511:0]  reg_out_a, reg_out_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [2][NR];

  always #5 pclk = ~pclk;

  apb_completer_regs #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_REGS(NR), .WAIT_STATES(2)
  ) u_dut_a (
    .pclk(pclk), .preset(preset), .psel(psel_a),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready_a), .prdata(prdata_a),
    .pslverr(pslverr_a), .reg_out(reg_out_a)
  );

  apb_completer_regs #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_REGS(NR), .WAIT_STATES(0)
  ) u_dut_b (
    .pclk(pclk), .preset(preset), .psel(psel_b),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready_b), .prdata(prdata_b),
    .pslverr(pslverr_b), .reg_out(reg_out_b)
  );

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] flat(input int d);
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = mdl[d][k];
    return v;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full transfer; returns one cycle after the completing cycle with
  // psel/penable still high so a caller may chain a setup immediately.
  task automatic xfer(input int d, input bit wr,
                      input logic [31:0] addr, input logic [31:0] data);
    int  ws, k;
    bit  seen, err;
    logic [31:0] exp_rd;
    ws      = (d == 0) ? 2 : 0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = data;
    penable = 1'b0;
    psel_a  = (d == 0);
    psel_b  = (d == 1);
    tick();
    penable = 1'b1;
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 20) begin
      if ((d == 0) ? pready_a : pready_b) begin
        seen = 1'b1;
      end else begin
        chk("prdata_not_ready",
            512'((d == 0) ? prdata_a : prdata_b), 512'(0));
        tick();
        k++;
      end
    end
    chk("latency", 512'(k), 512'(ws + 1));
    if (seen) begin
      err = (addr[1:0] != 2'b00) || ((addr >> 2) >= NR);
      exp_rd = err ? 32'h0 : mdl[d][addr[5:2]];
      chk("pslverr", 512'((d == 0) ? pslverr_a : pslverr_b), 512'(err));
      if (!wr)
        chk("prdata", 512'((d == 0) ? prdata_a : prdata_b), 512'(exp_rd));
      if (wr && !err) mdl[d][addr[5:2]] = data;
    end
    tick();
    chk("reg_out", (d == 0) ? reg_out_a : reg_out_b, flat(d));
  endtask

  initial begin
    int d;
    bit wr;
    int r;
    logic [31:0] a;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NR; k++) mdl[i][k] = '0;
    preset = 1'b1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) tick();
    chk("rst_pready", 512'(pready_a), 512'(0));
    chk("rst_pslverr", 512'(pslverr_a), 512'(0));
    chk("rst_prdata", 512'(prdata_a), 512'(0));
    chk("rst_reg_out", reg_out_a, 512'(0));
    preset = 1'b0;
    tick();

    // Reset asserted for two cycles in the middle of a waited write.
    paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hDEADBEEF;
    psel_a = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    preset = 1'b1;
    tick();
    chk("midrst_pready", 512'(pready_a), 512'(0));
    chk("midrst_prdata", 512'(prdata_a), 512'(0));
    chk("midrst_pslverr", 512'(pslverr_a), 512'(0));
    tick();
    preset = 1'b0;
    idle(1);
    chk("midrst_pready2", 512'(pready_a), 512'(0));
    chk("midrst_reg_out", reg_out_a, 512'(0));
    chk("midrst_reg2", 512'(reg_out_a[2*DW +: DW]), 512'(0));

    // Write then read with two wait states.
    xfer(0, 1'b1, 32'h4, 32'hA5A5_0001);
    idle(1);
    xfer(0, 1'b0, 32'h4, 32'h0);
    chk("slice1", 512'(reg_out_a[1*DW +: DW]), 512'(32'hA5A5_0001));
    idle(1);

    // Out of range and misaligned.
    xfer(0, 1'b1, 32'h40, 32'h1234);
    idle(1);
    xfer(0, 1'b0, 32'h40, 32'h0);
    idle(1);
    xfer(0, 1'b1, 32'h6, 32'hFFFF_FFFF);
    chk("misalign_reg1", 512'(reg_out_a[1*DW +: DW]), 512'(32'hA5A5_0001));
    idle(1);

    // Zero wait states, back-to-back with no idle cycle.
    xfer(1, 1'b1, 32'h0, 32'h1111_2222);
    xfer(1, 1'b1, 32'hC, 32'h3333_4444);
    idle(1);
    chk("zw_reg0", 512'(reg_out_b[0 +: DW]), 512'(32'h1111_2222));
    chk("zw_reg3", 512'(reg_out_b[3*DW +: DW]), 512'(32'h3333_4444));

    // Abort: psel dropped while waiting.
    paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hBAD0_BAD0;
    psel_a = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel_a = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_pready", 512'(pready_a), 512'(0));
      tick();
    end
    chk("abort_reg0", 512'(reg_out_a[0 +: DW]), 512'(mdl[0][0]));
    xfer(0, 1'b1, 32'h0, 32'h0BAD_F00D);
    idle(1);
    xfer(0, 1'b0, 32'h0, 32'h0);
    idle(1);

    // Randomized mix of legal, misaligned and out-of-range accesses.
    for (int i = 0; i < 80; i++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 6)
        a = 32'($urandom_range(0, NR - 1)) << 2;
      else if (r < 8)
        a = (32'($urandom_range(0, NR - 1)) << 2) | 32'($urandom_range(1, 3));
      else
        a = 32'($urandom_range(NR, 4095)) << 2;
      xfer(d, wr, a, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
    chk("final_a", reg_out_a, flat(0));
    chk("final_b", reg_out_b, flat(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
